// File: rtl/voice_scheduler.sv
// Per-sample-tick scheduler: walks the enabled voices through one shared waveshaper,
// sums their samples, normalizes the sum by the voice count on a shared divider and loads the PWM.
module voice_scheduler #(
  parameter int NVOICE = 12,
  parameter int SW     = 8,
  parameter int ACCW   = 12,
  parameter int TMO    = 1023
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          sample_now,
  input  logic [NVOICE-1:0]             voice_en,
  output logic                          ws_start,
  output logic [$clog2(NVOICE+1)-1:0]   ws_sel,
  input  logic                          ws_done,
  input  logic [SW-1:0]                 ws_sample,
  output logic                          div_start,
  output logic [ACCW-1:0]               div_dividend,
  output logic [ACCW-1:0]               div_divisor,
  input  logic                          div_done,
  input  logic [SW-1:0]                 div_quo,
  output logic                          pwm_start,
  output logic [SW-1:0]                 pwm_sample,
  output logic                          busy,
  output logic                          overrun,
  output logic                          timeout_err,
  output logic [2:0]                    dbg_state
);

  localparam int IW = $clog2(NVOICE + 1);
  localparam int TW = $clog2(TMO + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SCAN     = 3'd1,
    S_WAIT_WS  = 3'd2,
    S_NORM     = 3'd3,
    S_WAIT_DIV = 3'd4,
    S_OUTPUT   = 3'd5
  } state_e;

  // Handshakes: ws_start/div_start/pwm_start are single-cycle request strobes; ws_done/div_done are
  // single-cycle responses honoured only in the matching wait state and ignored everywhere else.
  state_e            state_q, state_d;
  logic [NVOICE-1:0] mask_q, mask_d;
  logic [ACCW-1:0]   acc_q, acc_d;
  logic [IW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              ws_start_q, ws_start_d;
  logic [IW-1:0]     ws_sel_q, ws_sel_d;
  logic              div_start_q, div_start_d;
  logic [ACCW-1:0]   div_dividend_q, div_dividend_d;
  logic [ACCW-1:0]   div_divisor_q, div_divisor_d;
  logic              pwm_start_q, pwm_start_d;
  logic [SW-1:0]     pwm_sample_q, pwm_sample_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic              timeout_q, timeout_d;

  logic scan_end;
  logic cur_en;
  logic timer_hit;

  assign scan_end  = (idx_q == IW'(NVOICE));
  assign cur_en    = |(mask_q & (NVOICE'(1) << idx_q));
  assign timer_hit = (timer_q == TW'(TMO));

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (sample_now) state_d = S_SCAN;
      S_SCAN: begin
        if (scan_end)    state_d = (cnt_q == '0) ? S_OUTPUT : S_NORM;
        else if (cur_en) state_d = S_WAIT_WS;
      end
      S_WAIT_WS:  if (ws_done || timer_hit) state_d = S_SCAN;
      S_NORM:     state_d = S_WAIT_DIV;
      S_WAIT_DIV: if (div_done) state_d = S_OUTPUT;
      S_OUTPUT:   state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; every strobe is raised on the edge entering its state
  always_comb begin
    mask_d         = mask_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    timer_d        = timer_q;
    ws_start_d     = 1'b0;
    ws_sel_d       = ws_sel_q;
    div_start_d    = 1'b0;
    div_dividend_d = div_dividend_q;
    div_divisor_d  = div_divisor_q;
    pwm_start_d    = 1'b0;
    pwm_sample_d   = pwm_sample_q;
    timeout_d      = 1'b0;
    overrun_d      = sample_now && (state_q != S_IDLE);
    busy_d         = (state_d != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (sample_now) begin
          mask_d = voice_en;
          acc_d  = '0;
          cnt_d  = '0;
          idx_d  = '0;
        end
      end
      S_SCAN: begin
        if (scan_end) begin
          if (cnt_q == '0) begin
            pwm_sample_d = '0;
            pwm_start_d  = 1'b1;
          end
        end else if (!cur_en) begin
          idx_d = idx_q + IW'(1);
        end else begin
          ws_sel_d   = idx_q;
          ws_start_d = 1'b1;
          timer_d    = '0;
        end
      end
      S_WAIT_WS: begin
        // A response in the same cycle as the timeout still counts
        if (ws_done) begin
          acc_d = acc_q + ACCW'(ws_sample);
          cnt_d = cnt_q + IW'(1);
          idx_d = idx_q + IW'(1);
        end else if (timer_hit) begin
          timeout_d = 1'b1;
          idx_d     = idx_q + IW'(1);
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_NORM: begin
        div_dividend_d = acc_q;
        div_divisor_d  = ACCW'(cnt_q);
        div_start_d    = 1'b1;
      end
      S_WAIT_DIV: begin
        if (div_done) begin
          pwm_sample_d = div_quo;
          pwm_start_d  = 1'b1;
        end
      end
      S_OUTPUT: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mask_q         <= '0;
      acc_q          <= '0;
      cnt_q          <= '0;
      idx_q          <= '0;
      timer_q        <= '0;
      ws_start_q     <= 1'b0;
      ws_sel_q       <= '0;
      div_start_q    <= 1'b0;
      div_dividend_q <= '0;
      div_divisor_q  <= '0;
      pwm_start_q    <= 1'b0;
      pwm_sample_q   <= '0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      mask_q         <= mask_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      timer_q        <= timer_d;
      ws_start_q     <= ws_start_d;
      ws_sel_q       <= ws_sel_d;
      div_start_q    <= div_start_d;
      div_dividend_q <= div_dividend_d;
      div_divisor_q  <= div_divisor_d;
      pwm_start_q    <= pwm_start_d;
      pwm_sample_q   <= pwm_sample_d;
      busy_q         <= busy_d;
      overrun_q      <= overrun_d;
      timeout_q      <= timeout_d;
    end
  end

  assign ws_start     = ws_start_q;
  assign ws_sel       = ws_sel_q;
  assign div_start    = div_start_q;
  assign div_dividend = div_dividend_q;
  assign div_divisor  = div_divisor_q;
  assign pwm_start    = pwm_start_q;
  assign pwm_sample   = pwm_sample_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;
  assign timeout_err  = timeout_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler: a scripted waveshaper/divider responder drives each frame
// and every scenario task checks its observations against hand-computed values.
module tb_voice_scheduler;

  localparam int TMO = 1023;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        sample_now = 1'b0;
  logic [11:0] voice_en = '0;
  logic        ws_start;
  logic [3:0]  ws_sel;
  logic        ws_done = 1'b0;
  logic [7:0]  ws_sample = '0;
  logic        div_start;
  logic [11:0] div_dividend;
  logic [11:0] div_divisor;
  logic        div_done = 1'b0;
  logic [7:0]  div_quo = '0;
  logic        pwm_start;
  logic [7:0]  pwm_sample;
  logic        busy;
  logic        overrun;
  logic        timeout_err;
  logic [2:0]  dbg_state;

  voice_scheduler dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .sample_now   (sample_now),
    .voice_en     (voice_en),
    .ws_start     (ws_start),
    .ws_sel       (ws_sel),
    .ws_done      (ws_done),
    .ws_sample    (ws_sample),
    .div_start    (div_start),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_done     (div_done),
    .div_quo      (div_quo),
    .pwm_start    (pwm_start),
    .pwm_sample   (pwm_sample),
    .busy         (busy),
    .overrun      (overrun),
    .timeout_err  (timeout_err),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0]  smp_tab [16];
  logic [3:0]  sel_q [$];
  logic [3:0]  exp_q [$];
  int          ws_cnt, div_cnt, pwm_cnt, ovr_cnt, tmo_cnt, extra_cnt;
  int          pwm_cyc, tmo_cyc, ws_start_cyc;
  logic [11:0] obs_dividend, obs_divisor;
  logic [7:0]  obs_pwm;
  logic        busy_c1, busy_after, frame_done;
  logic [44:0] all_out;

  assign all_out = {ws_start, ws_sel, div_start, div_dividend, div_divisor, pwm_start,
                    pwm_sample, busy, overrun, timeout_err, dbg_state};

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drives one frame from the tick (cycle 0) to pwm_start, acting as waveshaper and divider.
  task automatic run_frame(input logic [11:0] en, input logic [11:0] en_after,
                           input logic [7:0] quo, input bit ws_resp, input bit inject);
    int cyc;
    int div_wait;
    ws_cnt = 0; div_cnt = 0; pwm_cnt = 0; ovr_cnt = 0; tmo_cnt = 0; extra_cnt = 0;
    pwm_cyc = -1; tmo_cyc = -1; ws_start_cyc = -1;
    obs_dividend = '0; obs_divisor = '0; obs_pwm = '0;
    sel_q.delete();
    voice_en = en;
    sample_now = 1'b1;
    step();
    sample_now = 1'b0;
    voice_en = en_after;
    busy_c1 = busy;
    cyc = 1;
    div_wait = -1;
    frame_done = 1'b0;
    while (!frame_done && cyc < 3000) begin
      ws_done = 1'b0; div_done = 1'b0; sample_now = 1'b0;
      if (ws_start) begin
        ws_cnt++;
        sel_q.push_back(ws_sel);
        if (ws_cnt == 1) ws_start_cyc = cyc;
        if (ws_resp) begin
          ws_done = 1'b1;
          ws_sample = smp_tab[ws_sel];
        end
      end
      if (div_start) begin
        div_cnt++;
        obs_dividend = div_dividend;
        obs_divisor = div_divisor;
        div_wait = 3;
        if (inject) sample_now = 1'b1;
      end else if (div_wait > 0) begin
        div_wait--;
      end else if (div_wait == 0) begin
        div_done = 1'b1;
        div_quo = quo;
        div_wait = -1;
      end
      if (overrun) ovr_cnt++;
      if (timeout_err) begin
        tmo_cnt++;
        tmo_cyc = cyc;
      end
      if (pwm_start) begin
        pwm_cnt++;
        pwm_cyc = cyc;
        obs_pwm = pwm_sample;
        frame_done = 1'b1;
      end
      step();
      cyc++;
    end
    ws_done = 1'b0; div_done = 1'b0; sample_now = 1'b0;
    busy_after = busy;
    for (int i = 0; i < 3; i++) begin
      if (busy || ws_start || pwm_start || div_start) extra_cnt++;
      step();
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    step();
    step();
    checks++;
    if (all_out !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
    n_rst = 1'b1;
    step();
    step();
    checks++;
    if (all_out !== '0) begin
      failures++;
      $display("FAIL idle_after_reset: got %h expected 0", all_out);
    end
  endtask

  task automatic test_two_voices();
    for (int i = 0; i < 16; i++) smp_tab[i] = 8'd0;
    smp_tab[0] = 8'd200;
    smp_tab[3] = 8'd100;
    exp_q = '{4'd0, 4'd3};
    run_frame(12'h009, 12'hFF0, 8'd150, 1'b1, 1'b0);
    checks++;
    if (frame_done !== 1'b1) begin failures++; $display("FAIL two_done: got %0b expected 1", frame_done); end
    checks++;
    if (ws_cnt != 2) begin failures++; $display("FAIL two_ws_cnt: got %0d expected 2", ws_cnt); end
    while (exp_q.size() > 0 && sel_q.size() > 0) begin
      logic [3:0] e, g;
      e = exp_q.pop_front();
      g = sel_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL two_ws_sel: got %0d expected %0d", g, e); end
    end
    checks++;
    if (obs_dividend !== 12'd300) begin failures++; $display("FAIL two_dividend: got %0d expected 300", obs_dividend); end
    checks++;
    if (obs_divisor !== 12'd2) begin failures++; $display("FAIL two_divisor: got %0d expected 2", obs_divisor); end
    checks++;
    if (obs_pwm !== 8'd150 || pwm_cnt != 1) begin
      failures++; $display("FAIL two_pwm: got %0d x%0d expected 150 x1", obs_pwm, pwm_cnt);
    end
    checks++;
    if (busy_c1 !== 1'b1 || busy_after !== 1'b0) begin
      failures++; $display("FAIL two_busy: got %0b/%0b expected 1/0", busy_c1, busy_after);
    end
  endtask

  task automatic test_no_voices();
    run_frame(12'h000, 12'hFFF, 8'd99, 1'b1, 1'b0);
    checks++;
    if (ws_cnt != 0 || div_cnt != 0) begin
      failures++; $display("FAIL none_strobes: got ws=%0d div=%0d expected 0/0", ws_cnt, div_cnt);
    end
    checks++;
    if (pwm_cyc != 14) begin failures++; $display("FAIL none_latency: got %0d expected 14", pwm_cyc); end
    checks++;
    if (obs_pwm !== 8'd0) begin failures++; $display("FAIL none_pwm: got %0d expected 0", obs_pwm); end
    checks++;
    if (busy_after !== 1'b0) begin failures++; $display("FAIL none_busy_fall: got %0b expected 0", busy_after); end
  endtask

  task automatic test_all_voices();
    for (int i = 0; i < 16; i++) smp_tab[i] = 8'd255;
    exp_q.delete();
    for (int i = 0; i < 12; i++) exp_q.push_back(4'(i));
    run_frame(12'hFFF, 12'h000, 8'd255, 1'b1, 1'b0);
    checks++;
    if (ws_cnt != 12) begin failures++; $display("FAIL all_ws_cnt: got %0d expected 12", ws_cnt); end
    while (exp_q.size() > 0 && sel_q.size() > 0) begin
      logic [3:0] e, g;
      e = exp_q.pop_front();
      g = sel_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL all_ws_sel: got %0d expected %0d", g, e); end
    end
    checks++;
    if (obs_dividend !== 12'd3060) begin failures++; $display("FAIL all_dividend: got %0d expected 3060", obs_dividend); end
    checks++;
    if (obs_divisor !== 12'd12) begin failures++; $display("FAIL all_divisor: got %0d expected 12", obs_divisor); end
    checks++;
    if (obs_pwm !== 8'd255) begin failures++; $display("FAIL all_pwm: got %0d expected 255", obs_pwm); end
  endtask

  task automatic test_timeout();
    run_frame(12'h002, 12'h002, 8'd77, 1'b0, 1'b0);
    checks++;
    if (tmo_cnt != 1) begin failures++; $display("FAIL tmo_count: got %0d expected 1", tmo_cnt); end
    // Timer runs 0..TMO over the wait cycles starting with the ws_start cycle; the pulse is registered.
    checks++;
    if (tmo_cyc - ws_start_cyc != TMO + 1) begin
      failures++; $display("FAIL tmo_delay: got %0d expected %0d", tmo_cyc - ws_start_cyc, TMO + 1);
    end
    checks++;
    if (ws_cnt != 1 || div_cnt != 0) begin
      failures++; $display("FAIL tmo_strobes: got ws=%0d div=%0d expected 1/0", ws_cnt, div_cnt);
    end
    checks++;
    if (obs_pwm !== 8'd0 || pwm_cnt != 1) begin
      failures++; $display("FAIL tmo_pwm: got %0d x%0d expected 0 x1", obs_pwm, pwm_cnt);
    end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 16; i++) smp_tab[i] = 8'd0;
    smp_tab[0] = 8'd200;
    smp_tab[3] = 8'd100;
    run_frame(12'h009, 12'hFFF, 8'd150, 1'b1, 1'b1);
    checks++;
    if (ovr_cnt != 1) begin failures++; $display("FAIL ovr_count: got %0d expected 1", ovr_cnt); end
    checks++;
    if (obs_dividend !== 12'd300 || obs_pwm !== 8'd150) begin
      failures++; $display("FAIL ovr_result: got %0d/%0d expected 300/150", obs_dividend, obs_pwm);
    end
    checks++;
    if (busy_after !== 1'b0 || extra_cnt != 0) begin
      failures++; $display("FAIL ovr_no_restart: got busy=%0b extra=%0d expected 0/0", busy_after, extra_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    int waited;
    logic seen;
    voice_en = 12'h004;
    sample_now = 1'b1;
    step();
    sample_now = 1'b0;
    waited = 0;
    seen = 1'b0;
    while (!seen && waited < 20) begin
      seen = ws_start;
      if (!seen) begin
        step();
        waited++;
      end
    end
    checks++;
    if (seen !== 1'b1 || ws_sel !== 4'd2) begin
      failures++; $display("FAIL rst_mid_setup: got ws_start=%0b sel=%0d expected 1/2", seen, ws_sel);
    end
    n_rst = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin failures++; $display("FAIL rst_mid_async: got %h expected 0", all_out); end
    step();
    step();
    n_rst = 1'b1;
    div_quo = 8'd77;
    ws_sample = 8'd55;
    for (int i = 0; i < 4; i++) begin
      ws_done = (i % 2 == 0);
      div_done = (i % 2 == 1);
      step();
      checks++;
      if (all_out !== '0) begin failures++; $display("FAIL rst_idle_ignore[%0d]: got %h expected 0", i, all_out); end
    end
    ws_done = 1'b0;
    div_done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_two_voices();
    test_no_voices();
    test_all_voices();
    test_timeout();
    test_overrun();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
